// File: rtl/blink_sched.sv
// Blink period sequencer: countdown timer, LED toggle and boundary-aligned shift pulses.
// Optional level tracking and request saturation: define BLINK_LIMIT_EN.
module blink_sched #(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 8,
    parameter int MAX_LVL  = 3,
    parameter int INIT_LVL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_faster,
    input  logic             req_slower,
    input  logic [CNT_W-1:0] load_val,
    output logic             shift_left,
    output logic             shift_right,
    output logic             tick,
    output logic             led,
    output logic             busy,
    output logic             at_limit,
    output logic [2:0]       dbg_state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COUNT  = 3'd2,
        S_SHIFT  = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_presc;
    logic             r_led;
    logic             r_pend_f;
    logic             r_pend_s;
    logic             r_dir_f;
    logic             r_req_f_q;
    logic             r_req_s_q;

    logic w_strobe;
    logic w_term;
    logic w_accept;
    logic w_rise_f;
    logic w_rise_s;
    logic w_drop_f;
    logic w_drop_s;
    logic w_set_f;
    logic w_set_s;
    logic w_clr_f;
    logic w_clr_s;

    assign w_strobe = (r_presc == PRESC_MAX);
    assign w_term   = (r_state == S_COUNT) && w_strobe && (r_cnt == '0);
    assign w_accept = enable && (r_state != S_IDLE);
    assign w_rise_f = req_faster & ~r_req_f_q;
    assign w_rise_s = req_slower & ~r_req_s_q;

`ifdef BLINK_LIMIT_EN
    localparam int LW = (MAX_LVL > 0) ? $clog2(MAX_LVL + 1) : 1;
    logic [LW-1:0] r_lvl;

    assign w_drop_f = (r_lvl == LW'(0));
    assign w_drop_s = (r_lvl == LW'(MAX_LVL));
    assign at_limit = w_accept && ((w_rise_f && w_drop_f) || (w_rise_s && w_drop_s));

    // Level mirrors the shifter: right = faster = lower index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl <= LW'(INIT_LVL);
        end else if (shift_right && r_lvl != LW'(0)) begin
            r_lvl <= r_lvl - LW'(1);
        end else if (shift_left && r_lvl != LW'(MAX_LVL)) begin
            r_lvl <= r_lvl + LW'(1);
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_LVL > INIT_LVL);
    assign w_drop_f     = 1'b0;
    assign w_drop_s     = 1'b0;
    assign at_limit     = 1'b0;
`endif

    assign w_set_f = w_accept && w_rise_f && !w_drop_f;
    assign w_set_s = w_accept && w_rise_s && !w_drop_s;
    // Opposing requests that meet at a boundary cancel each other.
    assign w_clr_f = ((r_state == S_SHIFT) && r_dir_f) || (w_term && r_pend_f && r_pend_s);
    assign w_clr_s = ((r_state == S_SHIFT) && !r_dir_f) || (w_term && r_pend_f && r_pend_s);

    always_comb begin
        w_next      = r_state;
        tick        = 1'b0;
        shift_left  = 1'b0;
        shift_right = 1'b0;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_LOAD;
                S_LOAD:   w_next = S_COUNT;
                S_COUNT: begin
                    if (w_term) begin
                        tick   = 1'b1;
                        w_next = (r_pend_f ^ r_pend_s) ? S_SHIFT : S_LOAD;
                    end
                end
                S_SHIFT: begin
                    shift_right = r_dir_f;
                    shift_left  = !r_dir_f;
                    w_next      = S_SETTLE;
                end
                S_SETTLE: w_next = S_LOAD;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign led       = r_led;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_presc   <= '0;
            r_led     <= 1'b0;
            r_pend_f  <= 1'b0;
            r_pend_s  <= 1'b0;
            r_dir_f   <= 1'b0;
            r_req_f_q <= 1'b0;
            r_req_s_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_req_f_q <= req_faster;
            r_req_s_q <= req_slower;
            if (r_state == S_LOAD) begin
                r_cnt   <= load_val;
                r_presc <= '0;
            end else if (r_state == S_COUNT) begin
                r_presc <= w_strobe ? '0 : r_presc + PW'(1);
                if (w_strobe && r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            if (tick) begin
                r_led <= ~r_led;
            end
            if (w_term) begin
                r_dir_f <= r_pend_f;
            end
            // A fresh rise beats the clear of the bit being served.
            if (!w_accept) begin
                r_pend_f <= 1'b0;
                r_pend_s <= 1'b0;
            end else begin
                if (w_set_f)      r_pend_f <= 1'b1;
                else if (w_clr_f) r_pend_f <= 1'b0;
                if (w_set_s)      r_pend_s <= 1'b1;
                else if (w_clr_s) r_pend_s <= 1'b0;
            end
        end
    end

endmodule
